hilo_mul_ctrl: RTL

- Downstream consumer and controller of the two-cycle Booth/4-2-compressor multiplier in the 5-stage pipeline.
- Accepts HI/LO-class instructions from EX, launches the multiplier with correct signedness and operands, and captures its 64-bit product into HI/LO, with optional multiply-accumulate and multiply-subtract.
- Provides MFHI/MFLO read data and the EX stall for HI/LO hazards while a multiply is in flight.

---
 rtl/hilo_mul_ctrl_pkg.sv | 37 +++
 rtl/hilo_mul_ctrl_if.sv | 21 ++
 rtl/hilo_mul_ctrl_acc.sv | 24 ++
 rtl/hilo_mul_ctrl.sv | 84 ++++++++
 4 files changed

// File: rtl/hilo_mul_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply controller: EX opcodes, FSM states and
// opcode-class predicates.
package hilo_mul_ctrl_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_MTHI  = 4'd3;
  localparam logic [3:0] OP_MTLO  = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;
  localparam logic [3:0] OP_MFHI  = 4'd9;
  localparam logic [3:0] OP_MFLO  = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == OP_MULT)  || (op == OP_MULTU) ||
           (op == OP_MADD)  || (op == OP_MADDU) ||
           (op == OP_MSUB)  || (op == OP_MSUBU);
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  // Every opcode that reads or writes HI/LO; 11-15 behave as NOP.
  function automatic logic is_hilo_op(input logic [3:0] op);
    return (op >= OP_MULT) && (op <= OP_MFLO);
  endfunction

endpackage

// File: rtl/hilo_mul_ctrl_if.sv
// Launch/return bus between the HI/LO controller and the two-cycle multiplier.
interface hilo_mul_ctrl_if #(
  parameter int W = 32
);
  logic           mul_en;
  logic           mul_sig;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic [2*W-1:0] mul_c;
  logic           mul_done;

  modport master (
    output mul_en, mul_sig, mul_a, mul_b,
    input  mul_c, mul_done
  );

  modport slave (
    input  mul_en, mul_sig, mul_a, mul_b,
    output mul_c, mul_done
  );
endinterface

// File: rtl/hilo_mul_ctrl_acc.sv
// Next-{hi,lo} selector: pass, accumulate or subtract the product, modulo 2^(2W).
module hilo_acc
  import hilo_mul_ctrl_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [3:0]     op,
  input  logic [W-1:0]   hi,
  input  logic [W-1:0]   lo,
  input  logic [2*W-1:0] prod,
  output logic [2*W-1:0] nxt
);

  always_comb begin
    nxt = {hi, lo};
    case (op)
      OP_MULT, OP_MULTU: nxt = prod;
      OP_MADD, OP_MADDU: nxt = {hi, lo} + prod;
      OP_MSUB, OP_MSUBU: nxt = {hi, lo} - prod;
      default:           nxt = {hi, lo};
    endcase
  end

endmodule

// File: rtl/hilo_mul_ctrl.sv
// HI/LO controller: launches the multiplier from EX, retires its product into
// HI/LO one cycle later, and stalls HI/LO-class instructions meanwhile.
module hilo_mul_ctrl
  import hilo_mul_ctrl_pkg::*;
#(
  parameter int W = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 ex_valid,
  input  logic [3:0]           ex_op,
  input  logic [W-1:0]         ex_rs,
  input  logic [W-1:0]         ex_rt,
  input  logic                 ex_flush,
  output logic                 ex_stall,
  output logic [W-1:0]         mf_data,
  hilo_mul_ctrl_if.master      mul,
  output logic [W-1:0]         hi,
  output logic [W-1:0]         lo,
  output logic                 err
);

  state_t         state;
  logic [3:0]     pend_op;
  logic           live;
  logic           accept_mul;
  logic [2*W-1:0] hilo_nxt;

  // Gating with resetn keeps every combinational output at 0 while reset is held.
  assign live       = ex_valid && !ex_flush && resetn;
  assign accept_mul = (state == ST_IDLE) && live && is_mul_op(ex_op);

  assign mul.mul_en  = accept_mul;
  assign mul.mul_sig = accept_mul && is_signed_op(ex_op);
  assign mul.mul_a   = accept_mul ? ex_rs : '0;
  assign mul.mul_b   = accept_mul ? ex_rt : '0;

  assign ex_stall = (state == ST_WAIT) && ex_valid && is_hilo_op(ex_op);

  always_comb begin
    mf_data = '0;
    if (!ex_stall) begin
      if (ex_op == OP_MFHI)      mf_data = hi;
      else if (ex_op == OP_MFLO) mf_data = lo;
    end
  end

  hilo_acc #(.W(W)) u_acc (
    .op   (pend_op),
    .hi   (hi),
    .lo   (lo),
    .prod (mul.mul_c),
    .nxt  (hilo_nxt)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      pend_op <= OP_NOP;
      hi      <= '0;
      lo      <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (live && ex_op == OP_MTHI) hi <= ex_rs;
          if (live && ex_op == OP_MTLO) lo <= ex_rs;
          if (accept_mul) begin
            pend_op <= ex_op;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A missing mul_done is flagged, but the product is still retired.
          if (!mul.mul_done) err <= 1'b1;
          if (!ex_flush) {hi, lo} <= hilo_nxt;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
